// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MULT/DIV FSM
// encodings, register index width and default unit latencies.
package pipeline_hazard_ctrl_pkg;

    // GPR index width (rs/rt/rd fields)
    localparam int REG_IDX_W = 5;

    // Default cycles from MULT/DIV accept until HI/LO is valid
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;

    // MULT/DIV sequencer states; 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the ID/EX hazard inputs and the stage-register control outputs
// exchanged between the pipeline datapath and the hazard controller.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_IDX_W-1:0] idRs;
    logic [REG_IDX_W-1:0] idRt;
    logic                 idUsesRs;
    logic                 idUsesRt;
    logic                 exMemRead;
    logic [REG_IDX_W-1:0] exWriteReg;
    logic                 exBranchTaken;
    logic                 idMulDivStart;
    logic                 idIsDiv;
    logic                 idReadsHiLo;
    logic                 pcStall;
    logic                 ifidStall;
    logic                 ifidFlush;
    logic                 idexFlush;
    logic                 mdStart;
    logic                 mdBusy;
    logic                 mdDone;
    logic [CNT_W-1:0]     stallCycles;
    logic [CNT_W-1:0]     flushCount;

    // Datapath side: drives pipeline state, consumes controls
    modport master (
        output idRs, idRt, idUsesRs, idUsesRt, exMemRead, exWriteReg,
               exBranchTaken, idMulDivStart, idIsDiv, idReadsHiLo,
        input  pcStall, ifidStall, ifidFlush, idexFlush, mdStart, mdBusy,
               mdDone, stallCycles, flushCount
    );

    // Controller side
    modport slave (
        input  idRs, idRt, idUsesRs, idUsesRt, exMemRead, exWriteReg,
               exBranchTaken, idMulDivStart, idIsDiv, idReadsHiLo,
        output pcStall, ifidStall, ifidFlush, idexFlush, mdStart, mdBusy,
               mdDone, stallCycles, flushCount
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// MULT/DIV sequencer: accept decision, IDLE/BUSY/DONE FSM and the latency
// down-counter that times the unit until HI/LO is written.
module pipeline_hazard_ctrl_md_sequencer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
)(
    input  logic clk,
    input  logic rstN,
    input  logic start_req_s,
    input  logic is_div_s,
    input  logic hazard_stall_s,
    input  logic redirect_s,
    output logic accept_s,
    output logic busy_s,
    output logic done_s,
    output logic idle_s
);

    localparam int CW = $clog2(DIV_LAT) + 1;
    localparam logic [CW-1:0] MULT_RELOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_RELOAD  = CW'(DIV_LAT - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] reload_s;

    assign busy_s   = (state_q == MD_BUSY);
    assign done_s   = (state_q == MD_DONE);
    assign idle_s   = (state_q == MD_IDLE);
    assign reload_s = is_div_s ? DIV_RELOAD : MULT_RELOAD;
    // A new op may enter in IDLE or in the DONE cycle; never while reset is held
    assign accept_s = start_req_s & ~hazard_stall_s & ~redirect_s & ~busy_s & rstN;

    // Next-state and latency counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (accept_s) begin
                    state_d = MD_BUSY;
                    cnt_d   = reload_s;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MD_DONE: begin
                if (accept_s) begin
                    state_d = MD_BUSY;
                    cnt_d   = reload_s;
                end else begin
                    state_d = MD_IDLE;
                    cnt_d   = {CW{1'b0}};
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FSM and counter registers; reset aborts any op in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= MD_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use, HI/LO and MULT/DIV
// structural stalls, branch flushes, and stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
)(
    input  logic                   clk,
    input  logic                   rstN,
    pipeline_hazard_ctrl_if.slave  hz
);

    logic             load_use_s, hilo_haz_s, md_struct_s, stall_s;
    logic             accept_s, busy_s, done_s, idle_s;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    assign load_use_s = hz.exMemRead & (hz.exWriteReg != {REG_IDX_W{1'b0}}) &
                        ((hz.idUsesRs & (hz.idRs == hz.exWriteReg)) |
                         (hz.idUsesRt & (hz.idRt == hz.exWriteReg)));
    assign hilo_haz_s  = hz.idReadsHiLo & ~idle_s;
    assign md_struct_s = hz.idMulDivStart & busy_s;
    assign stall_s     = load_use_s | hilo_haz_s | md_struct_s;

    // A redirect discards the stalled wrong-path instruction instead of holding it
    assign hz.pcStall   = stall_s & ~hz.exBranchTaken;
    assign hz.ifidStall = stall_s & ~hz.exBranchTaken;
    assign hz.ifidFlush = hz.exBranchTaken;
    assign hz.idexFlush = stall_s | hz.exBranchTaken;
    assign hz.mdStart   = accept_s;
    assign hz.mdBusy    = busy_s;
    assign hz.mdDone    = done_s;
    assign hz.stallCycles = stall_cycles_q;
    assign hz.flushCount  = flush_count_q;

    pipeline_hazard_ctrl_md_sequencer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk            (clk),
        .rstN           (rstN),
        .start_req_s    (hz.idMulDivStart),
        .is_div_s       (hz.idIsDiv),
        .hazard_stall_s (stall_s),
        .redirect_s     (hz.exBranchTaken),
        .accept_s       (accept_s),
        .busy_s         (busy_s),
        .done_s         (done_s),
        .idle_s         (idle_s)
    );

    // Performance counter increments; both wrap freely
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_s) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (hz.exBranchTaken) begin
            flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_count_q  <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Expected control vectors and
// counter values are queued when a step is driven and compared at the
// following falling edge.
module tb_pipeline_hazard_ctrl;

    // {pcStall, ifidStall, ifidFlush, idexFlush, mdStart, mdBusy, mdDone}
    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_STALL = 7'b110_1000;
    localparam logic [6:0] C_BR    = 7'b001_1000;
    localparam logic [6:0] C_START = 7'b000_0100;
    localparam logic [6:0] C_BUSY  = 7'b000_0010;
    localparam logic [6:0] C_DONE  = 7'b000_0001;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk;
    logic rstN;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();

    pipeline_hazard_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .CNT_W    (32)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .hz   (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        hz.idRs          = 5'd0;
        hz.idRt          = 5'd0;
        hz.idUsesRs      = 1'b0;
        hz.idUsesRt      = 1'b0;
        hz.exMemRead     = 1'b0;
        hz.exWriteReg    = 5'd0;
        hz.exBranchTaken = 1'b0;
        hz.idMulDivStart = 1'b0;
        hz.idIsDiv       = 1'b0;
        hz.idReadsHiLo   = 1'b0;
    endtask

    task automatic check_front();
        exp_t       e;
        logic [6:0] obs;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=0 entries required=1");
        end else begin
            e   = sb.pop_front();
            obs = {hz.pcStall, hz.ifidStall, hz.ifidFlush, hz.idexFlush,
                   hz.mdStart, hz.mdBusy, hz.mdDone};
            n_checks++;
            assert (obs === e.ctl) else begin
                n_fail++;
                $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
            end
            n_checks++;
            assert (hz.stallCycles === e.sc) else begin
                n_fail++;
                $error("FAIL %s stallCycles observed=%0d expected=%0d", e.tag, hz.stallCycles, e.sc);
            end
            n_checks++;
            assert (hz.flushCount === e.fc) else begin
                n_fail++;
                $error("FAIL %s flushCount observed=%0d expected=%0d", e.tag, hz.flushCount, e.fc);
            end
        end
    endtask

    // One clock step: queue expectations, compare at negedge, advance model counters
    task automatic cyc(input string tag, input logic [6:0] exp_ctl, input bit exp_stall);
        exp_t e;
        e.tag = tag;
        e.ctl = exp_ctl;
        e.sc  = exp_sc;
        e.fc  = exp_fc;
        sb.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        if (rstN) begin
            if (exp_stall) exp_sc = exp_sc + 32'd1;
            if (hz.exBranchTaken) exp_fc = exp_fc + 32'd1;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_sc   = 32'd0;
        exp_fc   = 32'd0;
        clr();
        rstN = 1'b0;

        // Reset: equations still active, no start, counters frozen at 0
        cyc("rst_idle", C_NONE, 1'b0);
        hz.exMemRead = 1'b1; hz.exWriteReg = 5'd8; hz.idRs = 5'd8; hz.idUsesRs = 1'b1;
        cyc("rst_loaduse", C_STALL, 1'b1);
        clr(); hz.idMulDivStart = 1'b1;
        cyc("rst_no_start", C_NONE, 1'b0);
        clr(); rstN = 1'b1;
        cyc("idle", C_NONE, 1'b0);

        // Load-use variants
        hz.exMemRead = 1'b1; hz.exWriteReg = 5'd8; hz.idRs = 5'd8; hz.idUsesRs = 1'b1;
        cyc("lu_rs", C_STALL, 1'b1);
        clr();
        cyc("lu_drop", C_NONE, 1'b0);
        hz.exMemRead = 1'b1; hz.exWriteReg = 5'd0; hz.idRs = 5'd0; hz.idUsesRs = 1'b1;
        cyc("lu_r0", C_NONE, 1'b0);
        clr(); hz.exMemRead = 1'b1; hz.exWriteReg = 5'd5; hz.idRt = 5'd5; hz.idUsesRt = 1'b1;
        cyc("lu_rt", C_STALL, 1'b1);
        hz.idUsesRt = 1'b0;
        cyc("lu_rt_unused", C_NONE, 1'b0);
        hz.idUsesRt = 1'b1; hz.exMemRead = 1'b0;
        cyc("no_load", C_NONE, 1'b0);

        // Branch beats stall; branch blocks MULT accept
        clr(); hz.exMemRead = 1'b1; hz.exWriteReg = 5'd8; hz.idRs = 5'd8; hz.idUsesRs = 1'b1;
        hz.exBranchTaken = 1'b1;
        cyc("br_stall", C_BR, 1'b1);
        clr();
        cyc("br_after", C_NONE, 1'b0);
        hz.idMulDivStart = 1'b1; hz.exBranchTaken = 1'b1;
        cyc("br_no_start", C_BR, 1'b0);
        clr();
        cyc("br_no_busy", C_NONE, 1'b0);

        // MULT: start, 4 BUSY, DONE, IDLE
        hz.idMulDivStart = 1'b1;
        cyc("mul_start", C_START, 1'b0);
        clr();
        for (int i = 0; i < 4; i++) cyc("mul_busy", C_BUSY, 1'b0);
        cyc("mul_done", C_DONE, 1'b0);
        cyc("mul_idle", C_NONE, 1'b0);

        // DIV then MFHI: stalled through 32 BUSY + 1 DONE
        hz.idMulDivStart = 1'b1; hz.idIsDiv = 1'b1;
        cyc("div_start", C_START, 1'b0);
        clr(); hz.idReadsHiLo = 1'b1;
        for (int i = 0; i < 32; i++) cyc("div_hilo_busy", C_BUSY | C_STALL, 1'b1);
        cyc("div_hilo_done", C_DONE | C_STALL, 1'b1);
        cyc("mfhi_go", C_NONE, 1'b0);
        clr();
        cyc("idle2", C_NONE, 1'b0);

        // Back-to-back MULT: structural stall, accept in DONE, straight to BUSY
        hz.idMulDivStart = 1'b1;
        cyc("b2b_start", C_START, 1'b0);
        for (int i = 0; i < 4; i++) cyc("b2b_struct", C_BUSY | C_STALL, 1'b1);
        cyc("b2b_accept_done", C_DONE | C_START, 1'b0);
        clr();
        for (int i = 0; i < 4; i++) cyc("b2b_busy", C_BUSY, 1'b0);
        cyc("b2b_done", C_DONE, 1'b0);
        cyc("b2b_idle", C_NONE, 1'b0);

        // Reset during DIV aborts the op for good
        hz.idMulDivStart = 1'b1; hz.idIsDiv = 1'b1;
        cyc("div2_start", C_START, 1'b0);
        clr();
        for (int i = 0; i < 9; i++) cyc("div2_busy", C_BUSY, 1'b0);
        rstN   = 1'b0;
        exp_sc = 32'd0;
        exp_fc = 32'd0;
        cyc("rst_mid_div", C_NONE, 1'b0);
        rstN = 1'b1;
        for (int i = 0; i < 40; i++) cyc("post_rst_idle", C_NONE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
